// File: rtl/controlador_alu.sv
// Command sequencer in front of an external ALU. It holds a 4-entry operand
// register file and an N/Z/C/V flag register, and runs loads or ALU operations.
//
// state    | meaning
// IDLE     | ready for a command; loads and undefined ops complete from here
// EJECUTAR | ALU settles on latched operands; write-back and flags at cycle end
module controlador_alu #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_load,
  input  logic [3:0]   cmd_op,
  input  logic [1:0]   cmd_rd,
  input  logic [1:0]   cmd_ra,
  input  logic [1:0]   cmd_rb,
  input  logic [N-1:0] cmd_imm,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_control,
  input  logic [N-1:0] alu_resultado,
  input  logic         alu_negativo,
  input  logic         alu_cero,
  input  logic         alu_overflow,
  input  logic         alu_carry,
  output logic [3:0]   flags,
  output logic         done,
  output logic         error,
  input  logic [1:0]   rd_sel,
  output logic [N-1:0] rd_data
);

  typedef enum logic {IDLE = 1'b0, EJECUTAR = 1'b1} estadoT;

  estadoT       estado;
  estadoT       estadoSig;
  logic [N-1:0] regs [4];
  logic [1:0]   rdLatch;
  logic         aceptar;
  logic         opValida;
  logic         esAritmetica;

  assign cmd_ready    = (estado == IDLE) && !rst;
  assign aceptar      = cmd_valid && cmd_ready;
  assign opValida     = (cmd_op <= 4'd13);
  // Only ADD and SUB produce meaningful carry/overflow; other ops keep C and V.
  assign esAritmetica = (alu_control == 4'b1000) || (alu_control == 4'b1001);
  assign rd_data      = regs[rd_sel];

  always_comb begin
    estadoSig = estado;
    case (estado)
      IDLE:     if (aceptar && !cmd_load && opValida) estadoSig = EJECUTAR;
      EJECUTAR: estadoSig = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) estado <= IDLE;
    else     estado <= estadoSig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      rdLatch     <= '0;
      flags       <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (estado == EJECUTAR) begin
        regs[rdLatch] <= alu_resultado;
        flags[3]      <= alu_negativo;
        flags[2]      <= alu_cero;
        if (esAritmetica) begin
          flags[1] <= alu_carry;
          flags[0] <= alu_overflow;
        end
        done <= 1'b1;
      end else if (aceptar) begin
        if (cmd_load) begin
          regs[cmd_rd] <= cmd_imm;
          done         <= 1'b1;
        end else if (opValida) begin
          // Operands are captured here, so rd may safely alias ra or rb.
          alu_a       <= regs[cmd_ra];
          alu_b       <= regs[cmd_rb];
          alu_control <= cmd_op;
          rdLatch     <= cmd_rd;
        end else begin
          error <= 1'b1;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_controlador_alu.sv
// Bench for controlador_alu: behavioural ALU plus a transaction-level model of
// the register file, flags and completion timing, checked every cycle.
module tb_controlador_alu;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, cmd_valid, cmd_ready, cmd_load;
  logic [3:0]   cmd_op, alu_control, flags;
  logic [1:0]   cmd_rd, cmd_ra, cmd_rb, rd_sel;
  logic [N-1:0] cmd_imm, alu_a, alu_b, alu_resultado, rd_data;
  logic         alu_negativo, alu_cero, alu_overflow, alu_carry, done, error;

  always #5 clk = ~clk;

  // Returns {result, N, Z, C, V}; non-arithmetic ops drive junk C/V on purpose.
  function automatic logic [N+3:0] aluRef(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0]   s;
    logic [N-1:0] r;
    logic         c, v;
    c = a[0];
    v = b[N-1];
    s = '0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a ^ b;
      4'd3: r = ~(a & b);
      4'd4: r = ~(a | b);
      4'd5: r = ~a;
      4'd6: r = a << 1;
      4'd7: r = a >> 1;
      4'd8: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[N-1:0];
        c = s[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'd9: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[N-1:0];
        c = ~s[N];
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      default: r = b - a;
    endcase
    return {r, r[N-1], (r == '0), c, v};
  endfunction

  assign {alu_resultado, alu_negativo, alu_cero, alu_carry, alu_overflow} = aluRef(alu_control, alu_a, alu_b);

  controlador_alu #(.N(N)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra),
    .cmd_rb(cmd_rb), .cmd_imm(cmd_imm), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .alu_resultado(alu_resultado),
    .alu_negativo(alu_negativo), .alu_cero(alu_cero), .alu_overflow(alu_overflow),
    .alu_carry(alu_carry), .flags(flags), .done(done), .error(error),
    .rd_sel(rd_sel), .rd_data(rd_data)
  );

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int lastAcc = 0;
  bit mValid = 1'b0;
  bit logDone = 1'b0;
  int doneLog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: architectural state plus a list of pending write-backs due at a cycle.
  typedef struct {
    int           due;
    logic [1:0]   rd;
    logic [N-1:0] val;
    logic [3:0]   nzcv;
    bit           arith;
  } pendT;

  logic [N-1:0] mRegs [4];
  logic [N-1:0] mAluA, mAluB;
  logic [3:0]   mAluC, mFlags;
  bit           mErr, mDone, wasEmpty;
  pendT         pend[$];
  pendT         p;
  logic [N+3:0] r;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      foreach (mRegs[i]) mRegs[i] = '0;
      mAluA = '0; mAluB = '0; mAluC = '0; mFlags = '0;
      mErr = 1'b0; mDone = 1'b0;
      pend.delete();
      mValid = 1'b1;
    end else begin
      wasEmpty = (pend.size() == 0);
      mDone = 1'b0;
      while (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        mRegs[p.rd] = p.val;
        mFlags[3:2] = p.nzcv[3:2];
        if (p.arith) mFlags[1:0] = p.nzcv[1:0];
        mDone = 1'b1;
      end
      if (wasEmpty && cmd_valid) begin
        if (cmd_load) begin
          mRegs[cmd_rd] = cmd_imm;
          mDone = 1'b1;
        end else if (cmd_op > 4'd13) begin
          mErr = 1'b1;
          mDone = 1'b1;
        end else begin
          mAluA = mRegs[cmd_ra];
          mAluB = mRegs[cmd_rb];
          mAluC = cmd_op;
          r = aluRef(cmd_op, mAluA, mAluB);
          p.due = cyc + 1;
          p.rd = cmd_rd;
          p.val = r[N+3:4];
          p.nzcv = r[3:0];
          p.arith = (cmd_op == 4'd8) || (cmd_op == 4'd9);
          pend.push_back(p);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(!rst && pend.size() == 0));
      chk("done", 32'(done), 32'(mDone));
      chk("flags", 32'(flags), 32'(mFlags));
      chk("error", 32'(error), 32'(mErr));
      chk("rd_data", 32'(rd_data), 32'(mRegs[rd_sel]));
      chk("alu_a", 32'(alu_a), 32'(mAluA));
      chk("alu_b", 32'(alu_b), 32'(mAluB));
      chk("alu_control", 32'(alu_control), 32'(mAluC));
      if (logDone && done) doneLog.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rd_sel = 2'($urandom_range(0, 3));
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    cmd_load  = 1'($urandom);
    cmd_op    = 4'($urandom);
    cmd_rd    = 2'($urandom);
    cmd_ra    = 2'($urandom);
    cmd_rb    = 2'($urandom);
    cmd_imm   = N'($urandom);
    repeat (n) step();
  endtask

  // Leaves cmd_valid high so a following issue() is back-to-back.
  task automatic issue(input bit ld, input logic [3:0] op, input logic [1:0] rd,
                       input logic [1:0] ra, input logic [1:0] rb, input logic [N-1:0] imm);
    int n;
    bit rdy;
    cmd_valid = 1'b1;
    cmd_load = ld; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
    n = 0;
    do begin
      @(negedge clk);
      rdy = cmd_ready;
      step();
      n++;
    end while (!rdy && n < 8);
    lastAcc = cyc;
    chk("accept within bound", 32'(rdy), 32'd1);
  endtask

  task automatic peek(input string nm, input logic [1:0] i, input logic [N-1:0] e);
    rd_sel = i;
    #1;
    chk(nm, 32'(rd_data), 32'(e));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc0, acc1, acc2, k;
    int expDone[3];
    expDone = '{1, 3, 5};
    rst = 1'b1; cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 4'd0;
    cmd_rd = 2'd0; cmd_ra = 2'd0; cmd_rb = 2'd0; cmd_imm = '0; rd_sel = 2'd0;

    repeat (2) begin
      @(negedge clk);
      chk("ready low in reset", 32'(cmd_ready), 32'd0);
      step();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) peek("reg after reset", 2'(i), 4'b0000);
    chk("flags after reset", 32'(flags), 32'h0);
    chk("error after reset", 32'(error), 32'h0);

    issue(1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 4'b1010);
    chk("load R1 done", 32'(done), 32'd1);
    issue(1'b1, 4'd0, 2'd2, 2'd0, 2'd0, 4'b0110);
    chk("load R2 done", 32'(done), 32'd1);
    issue(1'b0, 4'b0000, 2'd3, 2'd1, 2'd2, '0);
    idle(0);
    chk("AND alu_a", 32'(alu_a), 32'b1010);
    chk("AND alu_b", 32'(alu_b), 32'b0110);
    idle(1);
    peek("AND R3", 2'd3, 4'b0010);
    chk("AND flags", 32'(flags), 32'b0000);

    issue(1'b0, 4'b1000, 2'd0, 2'd1, 2'd2, '0); idle(1);
    peek("ADD R0", 2'd0, 4'b0000);
    chk("ADD flags", 32'(flags), 32'b0110);
    issue(1'b0, 4'b0010, 2'd3, 2'd1, 2'd2, '0); idle(1);
    peek("XOR R3", 2'd3, 4'b1100);
    chk("XOR flags keep C V", 32'(flags), 32'b1010);

    issue(1'b0, 4'b1001, 2'd3, 2'd1, 2'd2, '0); idle(1);
    peek("SUB R3", 2'd3, 4'b0100);
    chk("SUB flags", 32'(flags), 32'b0011);
    issue(1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 4'b1111);
    issue(1'b0, 4'b1000, 2'd1, 2'd1, 2'd1, '0); idle(0);
    chk("ADD alias alu_a", 32'(alu_a), 32'b1111);
    idle(1);
    peek("ADD alias R1", 2'd1, 4'b1110);
    chk("ADD alias flags", 32'(flags), 32'b1010);

    issue(1'b0, 4'b1111, 2'd2, 2'd1, 2'd1, '0); idle(0);
    chk("undef op done", 32'(done), 32'd1);
    chk("undef op error", 32'(error), 32'd1);
    idle(1);
    peek("undef op R2 kept", 2'd2, 4'b0110);
    issue(1'b0, 4'b0000, 2'd2, 2'd1, 2'd1, '0);
    rst = 1'b1; cmd_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("abort no done", 32'(done), 32'd0);
    chk("abort error clear", 32'(error), 32'd0);
    peek("abort R2", 2'd2, 4'b0000);

    logDone = 1'b1;
    issue(1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 4'b0011); acc0 = lastAcc;
    issue(1'b0, 4'b1000, 2'd1, 2'd0, 2'd0, '0);   acc1 = lastAcc;
    issue(1'b0, 4'b0010, 2'd2, 2'd0, 2'd1, '0);   acc2 = lastAcc;
    idle(2);
    logDone = 1'b0;
    chk("b2b accept 1", 32'(acc1 - acc0), 32'd1);
    chk("b2b accept 2", 32'(acc2 - acc0), 32'd3);
    chk("b2b done count", 32'(doneLog.size()), 32'd3);
    for (int i = 0; i < 3 && i < doneLog.size(); i++)
      chk("b2b done cycle", 32'(doneLog[i] - acc0 + 1), 32'(expDone[i]));

    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 99);
      if (k < 4) begin
        rst = 1'b1;
        cmd_valid = 1'($urandom);
        step();
        rst = 1'b0;
      end else if (k < 35) begin
        issue(1'b1, 4'd0, 2'($urandom), 2'd0, 2'd0, N'($urandom));
      end else if (k < 40) begin
        issue(1'b0, 4'($urandom_range(14, 15)), 2'($urandom), 2'($urandom), 2'($urandom), '0);
      end else begin
        issue(1'b0, 4'($urandom_range(0, 13)), 2'($urandom), 2'($urandom), 2'($urandom), N'($urandom));
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/controlador_alu.md
# controlador_alu

Multi-cycle sequencer that sits directly upstream of `unidad_logico_aritmetica` and downstream of the instruction source. It holds a 4-entry operand register file and accepts commands over a valid/ready handshake. For each command it either loads an immediate or drives the ALU with registered operands, then writes the result back and updates a persistent N/Z/C/V flag register. The ALU itself stays external; this block only produces its inputs and consumes its outputs.

## Interface

**Parameters**
- `N`, default 4: datapath width; must match the ALU's width parameter.

**Ports**
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: a command is present.
- `cmd_ready`  out  1: block can accept a command; combinational, equals (state == IDLE) and not `rst`.
- `cmd_load`  in  1: 1 = load immediate; 0 = ALU operation.
- `cmd_op`  in  4: ALU control code, 0000–1101 valid.
- `cmd_rd`  in  2: destination register.
- `cmd_ra`  in  2: source register for operand A.
- `cmd_rb`  in  2: source register for operand B.
- `cmd_imm`  in  N: immediate value for loads.
- `alu_a`  out  N: registered operand A to the ALU.
- `alu_b`  out  N: registered operand B to the ALU.
- `alu_control`  out  4: registered control code to the ALU.
- `alu_resultado`  in  N: ALU result.
- `alu_negativo`, `alu_cero`, `alu_overflow`, `alu_carry`  in  1 each: ALU flags.
- `flags`  out  4: {N,Z,C,V} flag register.
- `done`  out  1: one-cycle pulse when a command completes.
- `error`  out  1: sticky; set by an undefined op code, cleared only by reset.
- `rd_sel`  in  2: observation read address.
- `rd_data`  out  N: combinational read of register `rd_sel`.

## Operation

- **Handshake:** a command is accepted on a rising edge where `cmd_valid` and `cmd_ready` are both 1. Command fields are sampled only at acceptance and ignored at all other times.

- **States:** IDLE, EJECUTAR.
- **IDLE, load accepted:** write `cmd_imm` to `regs[cmd_rd]`. Stay in IDLE. `done` is 1 on the next cycle. Flags are unchanged.
- **IDLE, op accepted with `cmd_op` ≤ 1101:**
  - Latch `regs[cmd_ra]` into `alu_a`, `regs[cmd_rb]` into `alu_b`, and `cmd_op` into `alu_control`.
  - Latch `cmd_rd` internally.
  - Go to EJECUTAR.
- **IDLE, op accepted with `cmd_op` 1110 or 1111:**
  - No register write. `alu_*` and flags are unchanged.
  - Set `error`. `done` pulses next cycle. Stay in IDLE.
- **EJECUTAR:** `cmd_ready` = 0. At the end of the cycle:
  - `regs[rd] <= alu_resultado`.
  - N <= `alu_negativo` and Z <= `alu_cero` for every op.
  - C <= `alu_carry` and V <= `alu_overflow` only when `alu_control` is 1000 or 1001. For all other ops, C and V hold.
  - `done` <= 1. Return to IDLE.
- **Operand capture:** operands are read at acceptance, so `rd` equal to `ra` or `rb` is safe.
- **`alu_*` hold:** `alu_*` outputs keep their last values while in IDLE.
- **Undriven `cmd_load`:** an X on `cmd_load` at acceptance is a bench error and is not handled.

**Reset** (synchronous; overrides every other action in the same cycle):
- All `regs`, `alu_a`, `alu_b`, `alu_control`, `flags`, `done` and `error` go to 0. State goes to IDLE.
- A reset asserted during EJECUTAR abandons the operation: no write-back, no flag update, no `done`.

## Timing

- **ALU op:** accepted at edge T. EJECUTAR occupies cycle T+1, with `alu_*` valid from the start of that cycle. The ALU therefore has one full cycle of combinational settle time. Write-back happens at edge T+2, and `rd_data` and `flags` reflect the new values from T+2. `done` is high for cycle T+2, and `cmd_ready` is 1 again in the same cycle.
- **Load:** accepted at T; register updated and `done` high from T+1.
- **Throughput:** one ALU op every 2 cycles; one load every cycle. With `cmd_valid` held high, back-to-back acceptance occurs with no idle gap.
- **`done` on consecutive loads:** `done` stays high continuously, one cycle per completion.

## Test plan

1. **Reset:** assert `rst` for 2 cycles with `cmd_valid` = 1 -> `cmd_ready` = 0 during reset. Afterwards all registers read 0000, `flags` = 0000, `error` = 0.
2. **Loads and AND:** load R1 = 1010, then R2 = 0110 -> each `done` one cycle later. Then AND (0000) R3 = R1, R2 -> `alu_a` = 1010 and `alu_b` = 0110 during EJECUTAR; R3 = 0010 two cycles after acceptance; N = 0, Z = 0.
3. **ADD and flag retention:** ADD (1000) R0 = R1 + R2 -> R0 = 0000, Z = 1, C = `alu_carry` (1). Next, XOR (0010) R3 = R1, R2 -> R3 = 1100, N = 1, Z = 0; C and V unchanged from the ADD.
4. **SUB overflow:** SUB (1001) R3 = R1 - R2 -> R3 = 0100, V = 1, N = 0. Then load R1 = 1111 and issue ADD R1 = R1 + R1 -> source value 1111 is used, and R1 = 1110 is written back.
5. **Undefined op and reset abort:** op 1111 -> no register changes, `error` = 1, `done` pulses. Then start AND into R2 and assert `rst` during EJECUTAR -> R2 reads 0000, no `done`, `error` = 0.
6. **Back-to-back:** hold `cmd_valid` through load, ALU op, ALU op -> acceptances at cycles 0, 1, 3; `done` at cycles 1, 3, 5.
